// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - synchronise and debounce a raw level, with registered edge pulses
// Optional SWITCH_DEBOUNCER_EDGE_CNT_EN adds an 8-bit rise counter output (edge_cnt).
module switch_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef SWITCH_DEBOUNCER_EDGE_CNT_EN
    ,
    output logic [7:0] edge_cnt
`endif
);

    if (STABLE_CYCLES < 1 || SYNC_STAGES < 2 || (STABLE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_err
        $error("switch_debouncer: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
    end

    typedef enum logic [1:0] {S_LOW, CHK_HIGH, S_HIGH, CHK_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   dout_n, rise_n, fall_n, busy_n;

    assign ds = sync_q[SYNC_STAGES-1];

    // The synchroniser keeps running while en=0 so ds is current when debouncing resumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
            rise  <= rise_n;
            fall  <= fall_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        if (en) begin
            case (state)
                S_LOW: begin
                    if (ds) begin
                        state_n = CHK_HIGH;
                        cnt_n   = '0;
                    end
                end
                CHK_HIGH: begin
                    if (!ds) begin
                        state_n = S_LOW;
                        cnt_n   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_n = S_HIGH;
                        cnt_n   = '0;
                        dout_n  = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!ds) begin
                        state_n = CHK_LOW;
                        cnt_n   = '0;
                    end
                end
                CHK_LOW: begin
                    if (ds) begin
                        state_n = S_HIGH;
                        cnt_n   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_n = S_LOW;
                        cnt_n   = '0;
                        dout_n  = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            endcase
        end
        // busy is registered from the next state so it tracks the CHK states exactly.
        busy_n = (state_n == CHK_HIGH) || (state_n == CHK_LOW);
    end

`ifdef SWITCH_DEBOUNCER_EDGE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 8'd0;
        end else if (rise_n) begin
            edge_cnt <= edge_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer
// Runs with SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=3 (edge-to-commit latency of 7 edges).
module tb_switch_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic dout, rise, fall, busy;
`ifdef SWITCH_DEBOUNCER_EDGE_CNT_EN
    logic [7:0] edge_cnt;
`endif

    int errors = 0;
    int checks = 0;

    switch_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .en  (en),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
`ifdef SWITCH_DEBOUNCER_EDGE_CNT_EN
        ,
        .edge_cnt(edge_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dout"}, dout, 1'b0);
        check({tag, ".rise"}, rise, 1'b0);
        check({tag, ".fall"}, fall, 1'b0);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    // Expected values indexed by edge number 1..8 after din changes just past edge 0
    logic [8:1] exp_busy_clean = 8'b0011_1100;
    logic [8:1] exp_lvl_commit = 8'b1100_0000;
    logic [8:1] exp_pulse      = 8'b0100_0000;
    logic [12:1] exp_busy_glitch = 12'b0000_0001_1100;

    initial begin
        rst = 1'b0;
        din = 1'b0;
        en  = 1'b1;
        #1;
        check_all_zero("reset_async");
        step(3);
        check_all_zero("reset_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_all_zero("idle");
        end

        // Clean press
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check($sformatf("press.busy@%0d", e), busy, exp_busy_clean[e]);
            check($sformatf("press.dout@%0d", e), dout, exp_lvl_commit[e]);
            check($sformatf("press.rise@%0d", e), rise, exp_pulse[e]);
            check($sformatf("press.fall@%0d", e), fall, 1'b0);
        end

        // Release from dout=1
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check($sformatf("release.busy@%0d", e), busy, exp_busy_clean[e]);
            check($sformatf("release.dout@%0d", e), dout, ~exp_lvl_commit[e]);
            check($sformatf("release.fall@%0d", e), fall, exp_pulse[e]);
            check($sformatf("release.rise@%0d", e), rise, 1'b0);
        end

        // Glitch: din high for three cycles only
        din = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (e == 3) din = 1'b0;
            check($sformatf("glitch.busy@%0d", e), busy, exp_busy_glitch[e]);
            check($sformatf("glitch.dout@%0d", e), dout, 1'b0);
            check($sformatf("glitch.rise@%0d", e), rise, 1'b0);
        end

        // Reset mid-check
        din = 1'b1;
        step(4);
        check("midrst.busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst.async");
        step(1);
        rst = 1'b1;
        step(6);
        check("midrst.dout@6", dout, 1'b0);
        step(1);
        check("midrst.dout@7", dout, 1'b1);
        check("midrst.rise@7", rise, 1'b1);

        // Reset while dout=1: drops with no fall pulse
        step(2);
        rst = 1'b0;
        din = 1'b0;
        #1;
        check_all_zero("rst_high.async");
        step(2);
        rst = 1'b1;
        step(4);
        check_all_zero("rst_high.after");

        // Enable freeze during CHK_HIGH
        din = 1'b1;
        step(4);
        check("freeze.busy_pre", busy, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("freeze.busy@%0d", i), busy, 1'b1);
            check($sformatf("freeze.rise@%0d", i), rise, 1'b0);
            check($sformatf("freeze.dout@%0d", i), dout, 1'b0);
        end
        en = 1'b1;
        step(2);
        check("freeze.busy_resume", busy, 1'b1);
        check("freeze.dout_resume", dout, 1'b0);
        step(1);
        check("freeze.dout_commit", dout, 1'b1);
        check("freeze.rise_commit", rise, 1'b1);
        check("freeze.busy_commit", busy, 1'b0);
        step(1);
        check("freeze.rise_end", rise, 1'b0);

`ifdef SWITCH_DEBOUNCER_EDGE_CNT_EN
        rst = 1'b0;
        din = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        checks++;
        assert (edge_cnt === 8'd0) else begin
            errors++;
            $error("FAIL edge_cnt.reset observed=%0d expected=0", edge_cnt);
        end
        for (int p = 0; p < 257; p++) begin
            din = 1'b1;
            step(9);
            din = 1'b0;
            step(9);
        end
        checks++;
        assert (edge_cnt === 8'd1) else begin
            errors++;
            $error("FAIL edge_cnt.wrap observed=%0d expected=1", edge_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
